// File: rtl/ext_ar_burst_gen_pkg.sv
// Shared constants and types for the external AR burst generator.
// Holds the fixed AXI attribute encodings driven onto every AR beat and
// the 4 KB page size that bounds each burst.
package ext_ar_burst_gen_pkg;

  localparam logic [2:0] AXI_SIZE_64        = 3'd3;     // 8-byte beats
  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT  = 4'b0010;  // normal non-cacheable, non-bufferable
  localparam logic [2:0] AXI_PROT_DEFAULT   = 3'b000;
  localparam logic [3:0] AXI_QOS_DEFAULT    = 4'b0000;
  localparam logic [3:0] AXI_REGION_DEFAULT = 4'b0000;
  localparam int unsigned PAGE_BYTES        = 4096;

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } ar_state_e;

endpackage

// File: rtl/ext_ar_burst_gen.sv
// ext_ar_burst_gen: splits a (start address, byte count) command into AXI
// INCR read bursts on a 64-bit bus. Bursts never cross a 4 KB page and
// never exceed MAX_BEATS beats; the first burst may start unaligned.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (accepted only when idle)
//   cmd_addr_i, cmd_bytes_i  start byte address, byte count (0 = no-op)
//   cmd_id_i, cmd_user_i     id/user replicated onto every burst
//   ar_valid_o/ar_ready_i    AR handshake toward ext_ar_buffer
//   ar_*_o                   AR channel fields
//   busy_o                   high while a command is being split
module ext_ar_burst_gen
  import ext_ar_burst_gen_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned USER_WIDTH  = 6,
  parameter int unsigned TRANS_WIDTH = 16,
  parameter int unsigned MAX_BEATS   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
  input  logic [TRANS_WIDTH-1:0] cmd_bytes_i,
  input  logic [ID_WIDTH-1:0]    cmd_id_i,
  input  logic [USER_WIDTH-1:0]  cmd_user_i,
  output logic                   ar_valid_o,
  input  logic                   ar_ready_i,
  output logic [ADDR_WIDTH-1:0]  ar_addr_o,
  output logic [7:0]             ar_len_o,
  output logic [2:0]             ar_size_o,
  output logic [1:0]             ar_burst_o,
  output logic                   ar_lock_o,
  output logic [3:0]             ar_cache_o,
  output logic [2:0]             ar_prot_o,
  output logic [3:0]             ar_region_o,
  output logic [3:0]             ar_qos_o,
  output logic [ID_WIDTH-1:0]    ar_id_o,
  output logic [USER_WIDTH-1:0]  ar_user_o,
  output logic                   busy_o
);

  // Wide enough for the byte count and for a full 4096-byte page distance.
  localparam int unsigned CW = ((TRANS_WIDTH > 13) ? TRANS_WIDTH : 13) + 1;

  ar_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [TRANS_WIDTH-1:0] rem_q, rem_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [USER_WIDTH-1:0]  user_q, user_d;

  logic [CW-1:0] rem_ext;
  logic [CW-1:0] page_left;
  logic [CW-1:0] beat_left;
  logic [CW-1:0] chunk;
  logic [CW-1:0] span;
  logic [7:0]    len;
  logic          ar_hs;
  logic          last_burst;

  // Burst sizing from registered state only, so AR fields hold steady
  // while a burst is stalled.
  always_comb begin
    rem_ext   = CW'(rem_q);
    page_left = CW'(PAGE_BYTES) - CW'(cur_addr_q[11:0]);
    beat_left = CW'(MAX_BEATS * 8) - CW'(cur_addr_q[2:0]);
    chunk     = rem_ext;
    if (page_left < chunk) chunk = page_left;
    if (beat_left < chunk) chunk = beat_left;
    // Beats covered = ceil((offset + chunk) / 8); len is beats - 1.
    span = CW'(cur_addr_q[2:0]) + chunk + CW'(7);
    // With nothing left (idle/reset) the subtraction would wrap; report 0.
    len  = (chunk == '0) ? '0 : 8'((span >> 3) - CW'(1));
  end

  assign ar_hs      = (state_q == ST_SPLIT) && ar_ready_i;
  assign last_burst = (rem_ext == chunk);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    id_d       = id_q;
    user_d     = user_q;
    unique case (state_q)
      ST_IDLE: begin
        // Zero-byte commands are consumed without touching state.
        if (cmd_valid_i && (cmd_bytes_i != '0)) begin
          cur_addr_d = cmd_addr_i;
          rem_d      = cmd_bytes_i;
          id_d       = cmd_id_i;
          user_d     = cmd_user_i;
          state_d    = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        if (ar_hs) begin
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(chunk);
          rem_d      = rem_q - TRANS_WIDTH'(chunk);
          if (last_burst) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      user_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      user_q     <= user_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign ar_valid_o  = (state_q == ST_SPLIT);
  assign busy_o      = (state_q == ST_SPLIT);

  assign ar_addr_o   = cur_addr_q;
  assign ar_len_o    = len;
  assign ar_id_o     = id_q;
  assign ar_user_o   = user_q;
  assign ar_size_o   = AXI_SIZE_64;
  assign ar_burst_o  = AXI_BURST_INCR;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = AXI_CACHE_DEFAULT;
  assign ar_prot_o   = AXI_PROT_DEFAULT;
  assign ar_region_o = AXI_REGION_DEFAULT;
  assign ar_qos_o    = AXI_QOS_DEFAULT;

endmodule

// File: tb/tb_ext_ar_burst_gen.sv
// Directed bench for ext_ar_burst_gen with hand-computed burst lists.
module tb_ext_ar_burst_gen;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_bytes;
  logic [3:0]  cmd_id;
  logic [5:0]  cmd_user;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_lock;
  logic [3:0]  ar_cache;
  logic [2:0]  ar_prot;
  logic [3:0]  ar_region;
  logic [3:0]  ar_qos;
  logic [3:0]  ar_id;
  logic [5:0]  ar_user;
  logic        busy;

  int unsigned n_total;
  int unsigned n_bad;

  ext_ar_burst_gen #(
    .ID_WIDTH    (4),
    .ADDR_WIDTH  (32),
    .USER_WIDTH  (6),
    .TRANS_WIDTH (16),
    .MAX_BEATS   (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_bytes_i (cmd_bytes),
    .cmd_id_i    (cmd_id),
    .cmd_user_i  (cmd_user),
    .ar_valid_o  (ar_valid),
    .ar_ready_i  (ar_ready),
    .ar_addr_o   (ar_addr),
    .ar_len_o    (ar_len),
    .ar_size_o   (ar_size),
    .ar_burst_o  (ar_burst),
    .ar_lock_o   (ar_lock),
    .ar_cache_o  (ar_cache),
    .ar_prot_o   (ar_prot),
    .ar_region_o (ar_region),
    .ar_qos_o    (ar_qos),
    .ar_id_o     (ar_id),
    .ar_user_o   (ar_user),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] b,
                          input logic [3:0] id, input logic [5:0] user);
    cmd_addr  = a;
    cmd_bytes = b;
    cmd_id    = id;
    cmd_user  = user;
    cmd_valid = 1'b1;
    check_eq("cmd_ready_before", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expects a burst to be presented (within max_wait cycles), checks it,
  // then lets it handshake (ar_ready assumed high).
  task automatic check_ar(input string tag, input logic [31:0] a, input logic [7:0] l,
                          input logic [3:0] id, input logic [5:0] user,
                          input int unsigned max_wait);
    for (int unsigned i = 0; i < max_wait && !ar_valid; i++) tick();
    check_eq({tag, "_valid"}, {63'd0, ar_valid}, 64'd1);
    check_eq({tag, "_addr"}, {32'd0, ar_addr}, {32'd0, a});
    check_eq({tag, "_len"}, {56'd0, ar_len}, {56'd0, l});
    check_eq({tag, "_id"}, {60'd0, ar_id}, {60'd0, id});
    check_eq({tag, "_user"}, {58'd0, ar_user}, {58'd0, user});
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
    check_eq({tag, "_cmdrdy"}, {63'd0, cmd_ready}, 64'd0);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_idle_valid"}, {63'd0, ar_valid}, 64'd0);
    check_eq({tag, "_idle_cmdrdy"}, {63'd0, cmd_ready}, 64'd1);
    check_eq({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_consts(input string tag);
    check_eq({tag, "_size"}, {61'd0, ar_size}, 64'd3);
    check_eq({tag, "_burst"}, {62'd0, ar_burst}, 64'd1);
    check_eq({tag, "_lock"}, {63'd0, ar_lock}, 64'd0);
    check_eq({tag, "_cache"}, {60'd0, ar_cache}, 64'd2);
    check_eq({tag, "_prot"}, {61'd0, ar_prot}, 64'd0);
    check_eq({tag, "_region"}, {60'd0, ar_region}, 64'd0);
    check_eq({tag, "_qos"}, {60'd0, ar_qos}, 64'd0);
  endtask

  initial begin
    int unsigned seen;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    cmd_id    = '0;
    cmd_user  = '0;
    ar_ready  = 1'b1;
    repeat (3) tick();

    // Reset state
    check_idle("rst");
    check_eq("rst_addr", {32'd0, ar_addr}, 64'd0);
    check_eq("rst_len", {56'd0, ar_len}, 64'd0);
    check_eq("rst_id", {60'd0, ar_id}, 64'd0);
    check_eq("rst_user", {58'd0, ar_user}, 64'd0);
    check_consts("rst");
    rst_n = 1'b1;
    tick();

    // Single aligned 128-byte burst
    send_cmd(32'h1000, 16'd128, 4'h3, 6'h15);
    check_ar("a1", 32'h1000, 8'd15, 4'h3, 6'h15, 0);
    check_idle("a");

    // 4 KB page split
    send_cmd(32'h0FF0, 16'd64, 4'h5, 6'h2A);
    check_ar("b1", 32'h0FF0, 8'd1, 4'h5, 6'h2A, 0);
    check_ar("b2", 32'h1000, 8'd5, 4'h5, 6'h2A, 0);
    check_idle("b");

    // Three back-to-back bursts
    send_cmd(32'h2000, 16'd300, 4'h7, 6'h01);
    check_ar("c1", 32'h2000, 8'd15, 4'h7, 6'h01, 0);
    check_ar("c2", 32'h2080, 8'd15, 4'h7, 6'h01, 0);
    check_consts("c");
    check_ar("c3", 32'h2100, 8'd5, 4'h7, 6'h01, 0);
    check_idle("c");

    // Unaligned short command, then a zero-byte command
    send_cmd(32'h3003, 16'd10, 4'h9, 6'h3F);
    check_ar("d1", 32'h3003, 8'd1, 4'h9, 6'h3F, 0);
    check_idle("d");
    send_cmd(32'h3100, 16'd0, 4'h1, 6'h01);
    check_idle("zero");
    tick();
    check_idle("zero2");

    // Unaligned start limited by MAX_BEATS: 123 bytes then 77
    send_cmd(32'h4005, 16'd200, 4'hA, 6'h0C);
    check_ar("e1", 32'h4005, 8'd15, 4'hA, 6'h0C, 0);
    check_ar("e2", 32'h4080, 8'd9, 4'hA, 6'h0C, 0);
    check_idle("e");

    // Unaligned start three bytes below a page: 3 bytes then 17
    send_cmd(32'h5FFD, 16'd20, 4'hB, 6'h10);
    check_ar("f1", 32'h5FFD, 8'd0, 4'hB, 6'h10, 0);
    check_ar("f2", 32'h6000, 8'd2, 4'hB, 6'h10, 0);
    check_idle("f");

    // Address wrap at the top of the address space
    send_cmd(32'hFFFF_FFF8, 16'd16, 4'hC, 6'h20);
    check_ar("g1", 32'hFFFF_FFF8, 8'd0, 4'hC, 6'h20, 0);
    check_ar("g2", 32'h0000_0000, 8'd0, 4'hC, 6'h20, 0);
    check_idle("g");

    // Backpressure on burst 2: fields must hold
    send_cmd(32'h2000, 16'd300, 4'h6, 6'h33);
    check_ar("h1", 32'h2000, 8'd15, 4'h6, 6'h33, 0);
    ar_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      check_eq("h_stall_valid", {63'd0, ar_valid}, 64'd1);
      check_eq("h_stall_addr", {32'd0, ar_addr}, 64'h2080);
      check_eq("h_stall_len", {56'd0, ar_len}, 64'd15);
      tick();
    end
    ar_ready = 1'b1;
    check_ar("h2", 32'h2080, 8'd15, 4'h6, 6'h33, 0);
    check_ar("h3", 32'h2100, 8'd5, 4'h6, 6'h33, 0);
    check_idle("h");

    // Reset while burst 2 is stalled: remaining bursts are dropped
    send_cmd(32'h2000, 16'd300, 4'h2, 6'h05);
    check_ar("r1", 32'h2000, 8'd15, 4'h2, 6'h05, 0);
    ar_ready = 1'b0;
    check_eq("r_pre_valid", {63'd0, ar_valid}, 64'd1);
    check_eq("r_pre_addr", {32'd0, ar_addr}, 64'h2080);
    rst_n = 1'b0;
    tick();
    check_idle("r");
    check_eq("r_addr", {32'd0, ar_addr}, 64'd0);
    check_eq("r_len", {56'd0, ar_len}, 64'd0);
    rst_n    = 1'b1;
    ar_ready = 1'b1;
    seen     = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (ar_valid) seen++;
      tick();
    end
    check_eq("r_no_more_ar", {32'd0, seen}, 64'd0);

    // Fresh command after the abandoned one works normally
    send_cmd(32'h1000, 16'd128, 4'h4, 6'h08);
    check_ar("s1", 32'h1000, 8'd15, 4'h4, 6'h08, 0);
    check_idle("s");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_ar_burst_gen.md
EXT_AR_BURST_GEN -- requirements
Module: ext_ar_burst_gen

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AR ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter USER_WIDTH, default 6, AR user width.
REQ-004 SHALL have parameter TRANS_WIDTH, default 16, command byte-count width.
REQ-005 SHALL have parameter MAX_BEATS, default 16, max beats per burst; power of two, 1..256.
REQ-006 SHALL have ports: clk_i  in  1  clock, single clock domain, rising edge.
REQ-007 rst_ni  in  1  reset, synchronous, active-low.
REQ-008 cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
REQ-009 cmd_addr_i  in  ADDR_WIDTH  start byte address; cmd_bytes_i  in  TRANS_WIDTH  byte count.
REQ-010 cmd_id_i  in  ID_WIDTH; cmd_user_i  in  USER_WIDTH  attached to every burst of the command.
REQ-011 ar_valid_o / ar_ready_i  out/in  1  AR handshake toward ext_ar_buffer slave side.
REQ-012 ar_addr_o ADDR_WIDTH, ar_len_o 8, ar_size_o 3, ar_burst_o 2, ar_lock_o 1, ar_cache_o 4, ar_prot_o 3, ar_region_o 4, ar_qos_o 4, ar_id_o ID_WIDTH, ar_user_o USER_WIDTH  out  AR fields.
REQ-013 busy_o  out  1  high while a command is being split.

Function
REQ-014 Data bus SHALL be 64-bit: ar_size_o = 3, ar_burst_o = INCR (2'b01) constant.
REQ-015 ar_lock_o, ar_prot_o, ar_region_o, ar_qos_o SHALL be 0; ar_cache_o SHALL be 4'b0010.
REQ-016 FSM SHALL have states IDLE and SPLIT; cmd_ready_o = (state==IDLE); ar_valid_o = busy_o = (state==SPLIT).
REQ-017 On cmd handshake with cmd_bytes_i>0: latch addr into cur_addr, bytes into rem, id, user; go SPLIT; ar_valid_o high the next cycle.
REQ-018 On cmd handshake with cmd_bytes_i==0: command consumed, no AR issued, stay IDLE.
REQ-019 Per burst: off = cur_addr[2:0]; chunk = min(rem, 4096 - cur_addr[11:0], MAX_BEATS*8 - off).
REQ-020 ar_addr_o = cur_addr (unaligned start allowed); ar_len_o = ceil((off+chunk)/8) - 1.
REQ-021 No burst SHALL cross a 4 KB boundary or exceed MAX_BEATS beats.
REQ-022 AR fields SHALL be combinational from registered state only, hence stable while ar_valid_o && !ar_ready_i.
REQ-023 On AR handshake: cur_addr += chunk (modulo 2^ADDR_WIDTH), rem -= chunk; if rem==chunk go IDLE, else stay SPLIT with next burst valid the following cycle (one burst per cycle under constant ready).
REQ-024 ar_valid_o SHALL never drop without a handshake.
REQ-025 Command and AR handshakes never coincide (cmd accepted only in IDLE); next command accepted earliest the cycle after the last AR handshake.

Reset
REQ-026 With rst_ni low at a rising edge: state=IDLE, cur_addr, rem, id, user = 0.
REQ-027 Reset outputs: cmd_ready_o=1, ar_valid_o=0, busy_o=0, ar_addr_o=0, ar_len_o=0, ar_id_o=0, ar_user_o=0.
REQ-028 Reset mid-SPLIT SHALL abandon remaining bursts; no AR emitted afterwards for that command.

Structure
REQ-029 Constants (AXI_SIZE_64, AXI_BURST_INCR, default cache/prot/qos/region, 4 KB page bytes) SHALL live in the shared mchan ext_unit package.
REQ-030 Single module, no sub-module; chunk/len computation is one combinational block in it; output feeds ext_ar_buffer directly.

Verification
REQ-031 addr 0x1000, bytes 128 -> one AR: addr 0x1000, len 15; cmd_ready_o high the cycle after the handshake.
REQ-032 addr 0x0FF0, bytes 64 -> AR 0x0FF0 len 1, then AR 0x1000 len 5 (4 KB split).
REQ-033 addr 0x2000, bytes 300, ready held high -> AR 0x2000 len 15, 0x2080 len 15, 0x2100 len 5 on consecutive cycles.
REQ-034 addr 0x3003, bytes 10 -> one AR addr 0x3003, len 1; bytes 0 -> no AR, cmd_ready_o stays high.
REQ-035 Scenario REQ-033 with ar_ready_i low 5 cycles on burst 2 -> fields stable, valid held; rst_ni low during burst 2 -> ar_valid_o 0 next cycle, cmd_ready_o 1, no further AR.
